// File: rtl/stream_sink_checker.sv
`default_nettype none
// ============================================================================
//  Module   : stream_sink_checker
//  Brief    : Valid/ready stream sink that checks an incrementing payload
//             sequence (k-th beat carries k mod 2^DATA_W), counts accepted
//             beats and mismatches, and flags completion after EXP_BEATS.
//  Options  : STREAM_SINK_CHECKER_BP_EN - when defined, o_ready in RUN follows
//             an 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) to apply pseudo-random
//             backpressure; when undefined, o_ready is held high in RUN.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_sink_checker #(
   parameter int         DATA_W    = 8,
   parameter int         EXP_BEATS = 16,
   parameter logic [7:0] LFSR_SEED = 8'hA5   // must be nonzero
) (
   input  logic              i_clk,
   input  logic              i_sync_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   output logic [15:0]       o_beat_cnt,
   output logic [15:0]       o_err_cnt,
   output logic              o_err,
   output logic              o_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Beat count value at which the accepting transfer completes the run.
   localparam logic [15:0] c_last_beat = 16'(EXP_BEATS - 1);
   localparam logic [15:0] c_err_max   = 16'hFFFF;

   state_t              r_state;
   state_t              w_state_next;
   logic                r_ready;
   logic                w_ready_next;
   logic                w_ready_src;
   logic [DATA_W-1:0]   r_expected;
   logic [15:0]         r_beat_cnt;
   logic [15:0]         r_err_cnt;
   logic                r_err;
   logic                w_xfer;
   logic                w_mismatch;

   assign w_xfer     = i_valid & r_ready;
   assign w_mismatch = w_xfer & (i_data != r_expected);

`ifdef STREAM_SINK_CHECKER_BP_EN
   // Right-shifting Galois form; the tap mask encodes x^8+x^6+x^5+x^4+1.
   // A nonzero seed keeps the register out of the all-zero lock-up state.
   localparam logic [7:0] c_lfsr_taps = 8'hB8;
   logic [7:0] r_lfsr;

   // Backpressure LFSR: advances once in every RUN cycle.
   always_ff @(posedge i_clk) begin
      if (i_sync_rst) begin
         r_lfsr <= LFSR_SEED;
      end else if (r_state == RUN) begin
         r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? c_lfsr_taps : 8'h00);
      end
   end

   assign w_ready_src = r_lfsr[0];
`else
   assign w_ready_src = 1'b1;
`endif

   // State and ready registers; o_ready never depends on i_valid.
   always_ff @(posedge i_clk) begin
      if (i_sync_rst) begin
         r_state <= IDLE;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_ready <= w_ready_next;
      end
   end

   // Next state and next ready: IDLE lasts one cycle, DONE only leaves on reset.
   always_comb begin
      w_state_next = r_state;
      w_ready_next = 1'b0;
      case (r_state)
         IDLE:    w_state_next = RUN;
         RUN: begin
            if (w_xfer && (r_beat_cnt == c_last_beat)) begin
               w_state_next = DONE;
            end
         end
         DONE:    w_state_next = DONE;
         default: w_state_next = IDLE;
      endcase
      w_ready_next = (w_state_next == RUN) & w_ready_src;
   end

   // Payload checking and counters; the expected value never resynchronises.
   always_ff @(posedge i_clk) begin
      if (i_sync_rst) begin
         r_expected <= '0;
         r_beat_cnt <= 16'd0;
         r_err_cnt  <= 16'd0;
         r_err      <= 1'b0;
      end else if (w_xfer) begin
         r_expected <= r_expected + 1'b1;
         r_beat_cnt <= r_beat_cnt + 16'd1;
         if (w_mismatch) begin
            r_err <= 1'b1;
            if (r_err_cnt != c_err_max) begin
               r_err_cnt <= r_err_cnt + 16'd1;
            end
         end
      end
   end

   assign o_ready    = r_ready;
   assign o_beat_cnt = r_beat_cnt;
   assign o_err_cnt  = r_err_cnt;
   assign o_err      = r_err;
   assign o_done     = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_stream_sink_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_sink_checker
//  Brief    : Self-checking bench for stream_sink_checker. Two instances:
//             DATA_W=8/EXP_BEATS=16 and DATA_W=4/EXP_BEATS=20, selected by
//             r_sel. Table-driven beat sequence, hand-written reset/idle/done
//             sequences and a randomized run against a counting model.
//  Options  : STREAM_SINK_CHECKER_BP_EN - enables backpressure-specific checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_sink_checker;

   logic        r_clk = 1'b0;
   logic        r_rst;
   logic        r_valid;
   logic        r_sel;
   logic [7:0]  r_data;

   logic        w_valid8, w_valid4;
   logic        w_ready8, w_ready4;
   logic [15:0] w_beat8, w_beat4, w_errc8, w_errc4;
   logic        w_err8, w_err4, w_done8, w_done4;

   logic        w_ready;
   logic [15:0] w_beat;
   logic [15:0] w_errc;
   logic        w_err;
   logic        w_done;

   int n_pass  = 0;
   int n_total = 0;

   always #5 r_clk = ~r_clk;

   assign w_valid8 = r_valid & ~r_sel;
   assign w_valid4 = r_valid &  r_sel;

   assign w_ready = r_sel ? w_ready4 : w_ready8;
   assign w_beat  = r_sel ? w_beat4  : w_beat8;
   assign w_errc  = r_sel ? w_errc4  : w_errc8;
   assign w_err   = r_sel ? w_err4   : w_err8;
   assign w_done  = r_sel ? w_done4  : w_done8;

   stream_sink_checker #(.DATA_W(8), .EXP_BEATS(16)) u_dut8 (
      .i_clk      (r_clk),
      .i_sync_rst (r_rst),
      .i_valid    (w_valid8),
      .o_ready    (w_ready8),
      .i_data     (r_data),
      .o_beat_cnt (w_beat8),
      .o_err_cnt  (w_errc8),
      .o_err      (w_err8),
      .o_done     (w_done8)
   );

   stream_sink_checker #(.DATA_W(4), .EXP_BEATS(20)) u_dut4 (
      .i_clk      (r_clk),
      .i_sync_rst (r_rst),
      .i_valid    (w_valid4),
      .o_ready    (w_ready4),
      .i_data     (r_data[3:0]),
      .o_beat_cnt (w_beat4),
      .o_err_cnt  (w_errc4),
      .o_err      (w_err4),
      .o_done     (w_done4)
   );

   typedef struct {
      logic [7:0]  data;
      logic [15:0] exp_beat;
      logic        exp_err;
      logic [15:0] exp_errc;
      logic        exp_done;
   } vec_t;

   vec_t tbl[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reset for one cycle; returns at the negedge after the reset edge (IDLE).
   task automatic do_reset();
      @(negedge r_clk);
      r_rst   = 1'b1;
      r_valid = 1'b0;
      @(negedge r_clk);
      r_rst   = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ready"}, w_ready, 0);
      check({tag, "_beat"},  w_beat,  0);
      check({tag, "_errc"},  w_errc,  0);
      check({tag, "_err"},   w_err,   0);
      check({tag, "_done"},  w_done,  0);
   endtask

   // Present one beat until it is accepted, then drop valid at the negedge
   // after the accepting edge, where the updated outputs are visible.
   task automatic send(input logic [7:0] d);
      bit got = 1'b0;
      for (int n = 0; n < 64 && !got; n++) begin
         @(negedge r_clk);
         r_valid = 1'b1;
         r_data  = d;
         got     = w_ready;
      end
      check("handshake", got, 1);
      @(negedge r_clk);
      r_valid = 1'b0;
   endtask

   // Random valid, payload held until accepted; model counts transfers.
   task automatic rand_run(input bit corrupt);
      int         m_cnt  = 0;
      int         m_errc = 0;
      bit         m_err  = 1'b0;
      bit         prev_xfer = 1'b0;
      logic [7:0] prev_data = 8'h00;
      int         tail  = 0;
      bit         seen0 = 1'b0;
      bit         seen1 = 1'b0;
      do_reset();
      for (int cyc = 0; cyc < 2000 && tail < 6; cyc++) begin
         @(negedge r_clk);
         if (prev_xfer) begin
            if (prev_data != 8'(m_cnt % 256)) begin
               m_errc++;
               m_err = 1'b1;
            end
            m_cnt++;
         end
         check("rand_beat", w_beat, m_cnt);
         check("rand_errc", w_errc, m_errc);
         check("rand_err",  w_err,  m_err);
         check("rand_done", w_done, (m_cnt >= 16));
         if (m_cnt >= 16) begin
            check("rand_ready_done", w_ready, 0);
            tail++;
         end else begin
            if (w_ready) seen1 = 1'b1;
            else         seen0 = 1'b1;
`ifndef STREAM_SINK_CHECKER_BP_EN
            check("rand_ready_run", w_ready, 1);
`endif
         end
         if (!(r_valid && !prev_xfer)) begin
            r_valid = ($urandom_range(0, 99) < 60);
            r_data  = 8'(m_cnt % 256);
            if (corrupt && ($urandom_range(0, 5) == 0))
               r_data = r_data ^ 8'(1 << $urandom_range(0, 7));
         end
         prev_xfer = r_valid && w_ready;
         prev_data = r_data;
      end
      r_valid = 1'b0;
      check("rand_completed", m_cnt, 16);
`ifdef STREAM_SINK_CHECKER_BP_EN
      check("bp_ready_varies", seen0 && seen1, 1);
`endif
      if (!corrupt) check("rand_no_err", w_err, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      r_rst   = 1'b1;
      r_valid = 1'b0;
      r_sel   = 1'b0;
      r_data  = 8'h00;

      // Beat 3 corrupt (7 instead of 3); no resync afterwards.
      for (int k = 0; k < 16; k++) begin
         tbl[k].data     = (k == 3) ? 8'd7 : 8'(k);
         tbl[k].exp_beat = 16'(k + 1);
         tbl[k].exp_err  = (k >= 3);
         tbl[k].exp_errc = (k >= 3) ? 16'd1 : 16'd0;
         tbl[k].exp_done = (k == 15);
      end

      // Reset with valid high: no transfer in the reset or IDLE cycle.
      @(negedge r_clk);
      r_rst   = 1'b1;
      r_valid = 1'b1;
      r_data  = 8'h55;
      @(negedge r_clk);
      r_rst = 1'b0;
      check_zero("idle");
      @(negedge r_clk);
      r_valid = 1'b0;
      check("idle_no_beat", w_beat, 0);
      check("idle_no_err",  w_err,  0);
`ifndef STREAM_SINK_CHECKER_BP_EN
      check("run_ready", w_ready, 1);
`endif

      // Table-driven corrupted sequence.
      for (int i = 0; i < 16; i++) begin
         send(tbl[i].data);
         check("tbl_beat", w_beat, tbl[i].exp_beat);
         check("tbl_err",  w_err,  tbl[i].exp_err);
         check("tbl_errc", w_errc, tbl[i].exp_errc);
         check("tbl_done", w_done, tbl[i].exp_done);
         if (tbl[i].exp_done) check("tbl_ready_done", w_ready, 0);
      end

      // Valid held in DONE: nothing changes.
      for (int i = 0; i < 4; i++) begin
         @(negedge r_clk);
         r_valid = 1'b1;
         r_data  = 8'd16;
      end
      @(negedge r_clk);
      r_valid = 1'b0;
      check("done_hold_beat",  w_beat,  16);
      check("done_hold_errc",  w_errc,  1);
      check("done_hold_done",  w_done,  1);
      check("done_hold_ready", w_ready, 0);

      // Reset from DONE clears everything.
      do_reset();
      check_zero("rst_done");

      // Reset pulsed after beat 5 with a would-be transfer in the reset cycle.
      for (int k = 0; k < 6; k++) send(8'(k));
      check("pre_rst_beat", w_beat, 6);
      @(negedge r_clk);
      r_rst   = 1'b1;
      r_valid = 1'b1;
      r_data  = 8'd6;
      @(negedge r_clk);
      r_rst   = 1'b0;
      r_valid = 1'b0;
      check_zero("midrun_rst");
      send(8'd0);
      check("restart_beat", w_beat, 1);
      check("restart_err",  w_err,  0);

      // Randomized runs against the counting model.
      rand_run(1'b0);
      rand_run(1'b1);

      // DATA_W=4, EXP_BEATS=20: expected value wraps 15 -> 0.
      r_sel = 1'b1;
      do_reset();
      for (int k = 0; k < 20; k++) begin
         send(8'(k % 16));
         check("w4_beat", w_beat, k + 1);
         if (k == 16) check("w4_wrap_err", w_err, 0);
      end
      check("w4_err",   w_err,   0);
      check("w4_errc",  w_errc,  0);
      check("w4_done",  w_done,  1);
      check("w4_ready", w_ready, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/stream_sink_checker.md
STREAM_SINK_CHECKER -- requirements
Module: stream_sink_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 8: stream data width in bits, legal range 2..32.
REQ-002 SHALL have parameter EXP_BEATS, default 16: number of beats expected per run, legal range 1..65535.
REQ-003 SHALL have parameter LFSR_SEED, default 8'hA5: nonzero seed of the backpressure LFSR.
REQ-004 SHALL have port i_clk, input, 1 bit: the only clock; all logic runs on its rising edge.
REQ-005 SHALL have port i_sync_rst, input, 1 bit: reset, synchronous to i_clk and active-high.
REQ-006 SHALL have port i_valid, input, 1 bit: initiator presents a beat.
REQ-007 SHALL have port o_ready, output, 1 bit: sink accepts a beat.
REQ-008 SHALL have port i_data, input, DATA_W bits: beat payload.
REQ-009 SHALL have port o_beat_cnt, output, 16 bits: number of accepted beats.
REQ-010 SHALL have port o_err_cnt, output, 16 bits: number of payload mismatches, saturating at 16'hFFFF.
REQ-011 SHALL have port o_err, output, 1 bit: sticky flag, set on the first mismatch.
REQ-012 SHALL have port o_done, output, 1 bit: high once EXP_BEATS beats have been accepted.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
- IDLE: exactly one cycle after reset release, then RUN.
- RUN: beats are accepted.
- DONE: o_ready=0; the FSM is absorbing and leaves only on reset.
REQ-014 SHALL accept a beat only in a cycle where i_valid=1 and o_ready=1 (a transfer).
REQ-015 SHALL drive o_ready from registers only, with no combinational path from i_valid.
REQ-016 SHALL require the k-th transfer (k from 0) to carry i_data == k mod 2^DATA_W; the expected value wraps from all-ones to 0.
REQ-017 SHALL, on each transfer, increment o_beat_cnt and the expected value in the next cycle (1-cycle latency).
REQ-018 SHALL, on a mismatching transfer, in the next cycle:
- set o_err;
- increment o_err_cnt, unless it is already at 16'hFFFF, where it holds.
REQ-019 SHALL not resynchronise the expected value after a mismatch; it still advances by one per transfer.
REQ-020 SHALL, on the transfer that makes o_beat_cnt equal EXP_BEATS, enter DONE in the next cycle, with o_done=1 and o_ready=0 in that same cycle.
REQ-021 SHALL ignore i_valid and i_data outside transfers: no counter, flag or expected-value change.

Reset
REQ-022 SHALL, while i_sync_rst=1, force in the following clock cycle:
- FSM=IDLE, o_ready=0, o_beat_cnt=0, o_err_cnt=0, o_err=0, o_done=0;
- expected value=0, LFSR=LFSR_SEED.
REQ-023 SHALL, when reset is asserted mid-run (including in DONE), discard all progress and restart from REQ-022 values.
REQ-024 SHALL take precedence over any simultaneous transfer: a transfer in a reset cycle is not counted.

Configuration
REQ-025 SHALL, when macro STREAM_SINK_CHECKER_BP_EN is defined, apply pseudo-random backpressure in RUN:
- an 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, advances every RUN cycle;
- o_ready = LFSR bit 0 registered;
- the LFSR never reaches the all-zero state.
REQ-026 SHALL, when STREAM_SINK_CHECKER_BP_EN is not defined:
- hold o_ready=1 throughout RUN;
- omit the LFSR logic;
- all other behaviour stays identical.

Verification
REQ-027 SHALL cover this scenario: no BP, DATA_W=8, EXP_BEATS=16, i_valid held 1, i_data=0..15 -> o_beat_cnt=16, o_err=0, o_err_cnt=0, o_done=1 one cycle after the 16th transfer, then o_ready=0.
REQ-028 SHALL cover this scenario: data 0,1,2,7,4,5,... (beat 3 corrupt) -> o_err=1 from the cycle after beat 3; final o_err_cnt=1; the remaining beats match (no resync).
REQ-029 SHALL cover this scenario: DATA_W=4, EXP_BEATS=20, data k mod 16 -> no error; the wrap at 15->0 is accepted.
REQ-030 SHALL cover this scenario: i_sync_rst pulsed 1 cycle after beat 5 -> all outputs return to 0 and the next run expects 0 first; a transfer during the reset cycle is ignored.
REQ-031 SHALL cover this scenario: BP enabled, i_valid toggled randomly, data held until transfer -> o_ready varies; o_beat_cnt equals the transfer count observed by the bench; o_err=0.
REQ-032 SHALL cover this scenario: i_valid=1 in IDLE and in DONE -> no count change.
